// File: rtl/tone_pkg.sv
// Tone generator shared constants: register offsets, stop bit and ms-tick helper.
// Pure declarations; no latency, no backpressure.
package tone_pkg;
  localparam int REGS_PER_CH = 2;
  localparam int OFF_HALF    = 0;  // offsets within a channel's register pair
  localparam int OFF_DUR     = 1;
  localparam int OFF_STATUS  = 0;  // relative to BASE_ADDR + REGS_PER_CH*NUM_CH
  localparam int STOP_BIT    = 31;

  function automatic int ms_tick_count(input int sys_freq_hz);
    return (sys_freq_hz / 1000 < 1) ? 1 : sys_freq_hz / 1000;
  endfunction
endpackage

// File: rtl/tone_channel.sv
// One tone channel: square oscillator and note gate; writes land on the same edge, no backpressure.
// Note-timeout counters exist only when TONE_DURATION_EN is defined.
module tone_channel
  import tone_pkg::*;
#(
  parameter int HALF_W = 24,
  parameter int DUR_W  = 16
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_half_we,
  input  logic              i_dur_we,
  input  logic [HALF_W-1:0] i_half_dat,
  input  logic [DUR_W-1:0]  i_dur_dat,
  input  logic              i_stop,
`ifdef TONE_DURATION_EN
  input  logic              i_tick,
`endif
  output logic [HALF_W-1:0] o_half,
  output logic [DUR_W-1:0]  o_dur,
  output logic              o_sq,
  output logic              o_active
);
  logic [HALF_W-1:0] r_half;
  logic [HALF_W-1:0] r_phase;
  logic [DUR_W-1:0]  r_dur;
  logic              r_sq;
  logic              r_active;

  // A half-period write restarts the phase but leaves the square level alone.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_half  <= '0;
      r_phase <= '0;
      r_sq    <= 1'b0;
    end else if (i_half_we) begin
      r_half  <= i_half_dat;
      r_phase <= '0;
    end else if (r_half == '0) begin
      r_phase <= '0;
      r_sq    <= 1'b0;
    end else if (r_phase == r_half - HALF_W'(1)) begin
      r_phase <= '0;
      r_sq    <= ~r_sq;
    end else begin
      r_phase <= r_phase + HALF_W'(1);
    end
  end

`ifdef TONE_DURATION_EN
  logic [DUR_W-1:0] r_rem;

  // A DUR write outranks an expiry tick on the same edge.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_dur    <= '0;
      r_rem    <= '0;
      r_active <= 1'b0;
    end else if (i_dur_we) begin
      r_dur    <= i_dur_dat;
      r_rem    <= i_dur_dat;
      r_active <= ~i_stop;
    end else if (i_tick && r_active && (r_rem != '0)) begin
      r_rem <= r_rem - DUR_W'(1);
      if (r_rem == DUR_W'(1)) r_active <= 1'b0;
    end
  end
`else
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_dur    <= '0;
      r_active <= 1'b0;
    end else if (i_dur_we) begin
      r_dur    <= i_dur_dat;
      r_active <= ~i_stop && (i_dur_dat != '0);
    end
  end
`endif

  assign o_half   = r_half;
  assign o_dur    = r_dur;
  assign o_sq     = r_sq;
  assign o_active = r_active;
endmodule

// File: rtl/mmio_tone_gen.sv
// MMIO polyphonic square-wave generator mixed to one PWM pin; reads combinational, audio_out one cycle after the frame counter.
// No backpressure (bus writes always accepted); TONE_DURATION_EN enables ms-timed notes.
module mmio_tone_gen
  import tone_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int SYS_FREQ_HZ = 50000000,
  parameter int BASE_ADDR   = 4098,
  parameter int HALF_W      = 24,
  parameter int DUR_W       = 16,
  parameter int PWM_PERIOD  = 1000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  input  logic              wren,
  output logic              hit,
  output logic [31:0]       rdata,
  output logic [NUM_CH-1:0] active,
  output logic              audio_out
);
  localparam int LAST_OFF = REGS_PER_CH * NUM_CH + OFF_STATUS;
  localparam int STEP     = PWM_PERIOD / NUM_CH;
  localparam int PW       = $clog2(PWM_PERIOD + 1);

  logic              w_hit;
  logic [31:0]       w_off;
  logic [HALF_W-1:0] w_half [NUM_CH];
  logic [DUR_W-1:0]  w_dur  [NUM_CH];
  logic [NUM_CH-1:0] w_sq;
  logic [NUM_CH-1:0] w_active;
  logic              w_unused;

  assign w_hit    = (addr >= 32'(BASE_ADDR)) && (addr <= 32'(BASE_ADDR + LAST_OFF));
  assign w_off    = addr - 32'(BASE_ADDR);
  assign w_unused = ^wdata;

`ifdef TONE_DURATION_EN
  localparam int TICK_N = ms_tick_count(SYS_FREQ_HZ);
  localparam int TW     = (TICK_N > 1) ? $clog2(TICK_N) : 1;

  logic [TW-1:0] r_presc;
  logic          w_tick;

  // Free-running; bus writes never realign it.
  assign w_tick = (r_presc == TW'(TICK_N - 1));

  always_ff @(posedge clock) begin
    if (reset) r_presc <= '0;
    else       r_presc <= w_tick ? '0 : r_presc + TW'(1);
  end
`endif

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic w_half_we;
    logic w_dur_we;

    assign w_half_we = wren && w_hit && (w_off == 32'(REGS_PER_CH * c + OFF_HALF));
    assign w_dur_we  = wren && w_hit && (w_off == 32'(REGS_PER_CH * c + OFF_DUR));

    tone_channel #(
      .HALF_W (HALF_W),
      .DUR_W  (DUR_W)
    ) u_ch (
      .i_clock    (clock),
      .i_reset    (reset),
      .i_half_we  (w_half_we),
      .i_dur_we   (w_dur_we),
      .i_half_dat (wdata[HALF_W-1:0]),
      .i_dur_dat  (wdata[DUR_W-1:0]),
      .i_stop     (wdata[STOP_BIT]),
`ifdef TONE_DURATION_EN
      .i_tick     (w_tick),
`endif
      .o_half     (w_half[c]),
      .o_dur      (w_dur[c]),
      .o_sq       (w_sq[c]),
      .o_active   (w_active[c])
    );
  end

  always_comb begin
    rdata = '0;
    if (w_hit) begin
      if (w_off == 32'(LAST_OFF)) rdata = 32'(w_active);
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_off == 32'(REGS_PER_CH * c + OFF_HALF)) rdata = 32'(w_half[c]);
        if (w_off == 32'(REGS_PER_CH * c + OFF_DUR))  rdata = 32'(w_dur[c]);
      end
    end
  end

  logic [PW-1:0] r_pwm;
  logic [PW-1:0] r_level;
  logic [PW-1:0] w_level;
  logic [PW-1:0] w_frame_level;
  logic          r_audio;

  always_comb begin
    w_level = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_active[c] && w_sq[c]) w_level = w_level + PW'(STEP);
    end
  end

  // Level is frozen at frame start so a channel edge never cuts a PWM pulse.
  assign w_frame_level = (r_pwm == '0) ? w_level : r_level;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_pwm   <= '0;
      r_level <= '0;
      r_audio <= 1'b0;
    end else begin
      r_pwm   <= (r_pwm == PW'(PWM_PERIOD - 1)) ? '0 : r_pwm + PW'(1);
      if (r_pwm == '0) r_level <= w_level;
      r_audio <= (r_pwm < w_frame_level);
    end
  end

  assign hit       = w_hit;
  assign active    = w_active;
  assign audio_out = r_audio;
endmodule

// File: tb/tb_mmio_tone_gen.sv
// Self-checking bench for mmio_tone_gen: directed scenarios plus random bus traffic
// against a time-based reference model of oscillators, notes and the PWM mixer.
`timescale 1ns/1ps
module tb_mmio_tone_gen;
  localparam int NUM_CH      = 4;
  localparam int SYS_FREQ_HZ = 10000;
  localparam int BASE        = 4098;
  localparam int HALF_W      = 24;
  localparam int DUR_W       = 16;
  localparam int PWM_PERIOD  = 8;
  localparam int TICK        = 10;
  localparam int STEP        = PWM_PERIOD / NUM_CH;
  localparam int LAST        = BASE + 2 * NUM_CH;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [31:0]       addr  = '0;
  logic [31:0]       wdata = '0;
  logic              wren  = 1'b0;
  logic              hit;
  logic [31:0]       rdata;
  logic [NUM_CH-1:0] active;
  logic              audio_out;

  mmio_tone_gen #(
    .NUM_CH      (NUM_CH),
    .SYS_FREQ_HZ (SYS_FREQ_HZ),
    .BASE_ADDR   (BASE),
    .HALF_W      (HALF_W),
    .DUR_W       (DUR_W),
    .PWM_PERIOD  (PWM_PERIOD)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .addr      (addr),
    .wdata     (wdata),
    .wren      (wren),
    .hit       (hit),
    .rdata     (rdata),
    .active    (active),
    .audio_out (audio_out)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // Reference model: each channel is described by its last HALF write (edge, value,
  // level at that moment) and its note (on flag, expiry edge; 0 = never expires).
  int unsigned m_half [NUM_CH];
  int unsigned m_dur  [NUM_CH];
  int          m_hw   [NUM_CH];
  bit          m_hs   [NUM_CH];
  bit          m_on   [NUM_CH];
  int          m_exp  [NUM_CH];
  int          m_level;
  bit          m_audio;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", tag, cyc, got, exp);
    end
  endtask

  function automatic bit sq_at(input int c, input int k);
    if (m_half[c] == 0) return (k == m_hw[c]) ? m_hs[c] : 1'b0;
    return m_hs[c] ^ ((((k - m_hw[c]) / int'(m_half[c])) % 2) == 1);
  endfunction

  function automatic bit act_at(input int c, input int k);
    return m_on[c] && (m_exp[c] == 0 || k < m_exp[c]);
  endfunction

  function automatic logic [NUM_CH-1:0] exp_act(input int k);
    logic [NUM_CH-1:0] v = '0;
    for (int c = 0; c < NUM_CH; c++) v[c] = act_at(c, k);
    return v;
  endfunction

  task automatic exp_read(input logic [31:0] a, input int k, output logic eh, output logic [31:0] ed);
    int off;
    eh = 1'b0;
    ed = '0;
    if (a >= BASE && a <= LAST) begin
      eh  = 1'b1;
      off = int'(a - BASE);
      if (off == 2 * NUM_CH)  ed = 32'(exp_act(k));
      else if (off % 2 == 0)  ed = m_half[off / 2];
      else                    ed = m_dur[off / 2];
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_half[c] = 0; m_dur[c] = 0; m_hw[c] = 0;
      m_hs[c] = 1'b0; m_on[c] = 1'b0; m_exp[c] = 0;
    end
    m_level = 0;
    m_audio = 1'b0;
    cyc     = 0;
  endtask

  // One clock: advance the model on the posedge, compare outputs on the negedge.
  task automatic step();
    int k, lvl, c;
    logic eh;
    logic [31:0] ed;
    @(posedge clock);
    if (reset) begin
      model_reset();
    end else begin
      k = cyc + 1;
      if ((k - 1) % PWM_PERIOD == 0) begin
        lvl = 0;
        for (int i = 0; i < NUM_CH; i++)
          if (act_at(i, k - 1) && sq_at(i, k - 1)) lvl += STEP;
        m_level = lvl;
      end
      m_audio = ((k - 1) % PWM_PERIOD) < m_level;
      if (wren && addr >= BASE && addr < LAST) begin
        c = int'(addr - BASE) / 2;
        if (int'(addr - BASE) % 2 == 0) begin
          m_hs[c]   = sq_at(c, k - 1);
          m_half[c] = int'(wdata[HALF_W-1:0]);
          m_hw[c]   = k;
        end else begin
          m_dur[c] = int'(wdata[DUR_W-1:0]);
          if (wdata[31]) begin
            m_on[c] = 1'b0;
          end else begin
`ifdef TONE_DURATION_EN
            m_on[c]  = 1'b1;
            m_exp[c] = (m_dur[c] == 0) ? 0 : ((k / TICK) + 1) * TICK + (int'(m_dur[c]) - 1) * TICK;
`else
            m_on[c]  = (m_dur[c] != 0);
            m_exp[c] = 0;
`endif
          end
        end
      end
      cyc = k;
    end
    @(negedge clock);
    check("audio_out", 32'(audio_out), 32'(m_audio));
    check("active", 32'(active), 32'(exp_act(cyc)));
    exp_read(addr, cyc, eh, ed);
    check("hit", 32'(hit), 32'(eh));
    check("rdata", rdata, ed);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    addr  = 32'(a);
    wdata = d;
    wren  = 1'b1;
    step();
    wren  = 1'b0;
    wdata = '0;
  endtask

  initial begin
    int n, r, ch;
    model_reset();
    @(negedge clock);

    // Reset state
    reset = 1'b1;
    addr  = 32'(BASE + 8);
    idle(3);
    check("rst_status", rdata, 32'h0);
    check("rst_active", 32'(active), 32'h0);
    check("rst_audio", 32'(audio_out), 32'h0);
    reset = 1'b0;
    idle(2);

    // Single channel frequency
    wr(BASE + 0, 32'd5);
    wr(BASE + 1, 32'd0);
    idle(48);

    // Note duration
    wr(BASE + 2, 32'd4);
    wr(BASE + 3, 32'd3);
    n = 0;
    while (active[1] && n < 40) begin
      step();
      n++;
    end
`ifdef TONE_DURATION_EN
    check("dur_expire_window", 32'(n >= 21 && n <= 30), 32'd1);
`else
    check("dur_sustain", 32'(active[1]), 32'd1);
`endif

    // Restart on the expiry tick, then stop bit
    wr(BASE + 5, 32'd5);
    n = 0;
    while (m_exp[2] != 0 && cyc + 1 < m_exp[2] && n < 100) begin
      step();
      n++;
    end
    wr(BASE + 5, 32'd5);
    idle(2);
    check("restart_hold", 32'(active[2]), 32'd1);
    wr(BASE + 5, 32'h8000_0000);
    check("stop_bit", 32'(active[2]), 32'd0);

    // Mixing
    for (int c = 0; c < NUM_CH; c++) wr(BASE + 2 * c, 32'd7);
    for (int c = 0; c < NUM_CH; c++) wr(BASE + 2 * c + 1, 32'd0);
    idle(64);
    wr(BASE + 0, 32'd0);
    idle(40);

    // Decode
    addr = 32'(BASE - 1);
    step();
    check("dec_lo_hit", 32'(hit), 32'd0);
    check("dec_lo_rdata", rdata, 32'h0);
    addr = 32'(BASE + 9);
    step();
    check("dec_hi_hit", 32'(hit), 32'd0);
    check("dec_hi_rdata", rdata, 32'h0);
    wr(BASE + 2, 32'h00AB_CDEF);
    addr = 32'(BASE + 2);
    step();
    check("half1_readback", rdata, 32'h00AB_CDEF);

    // Random traffic
    for (int it = 0; it < 300; it++) begin
      r  = $urandom_range(0, 9);
      ch = $urandom_range(0, NUM_CH - 1);
      if (r <= 3) begin
        wr(BASE + 2 * ch, ($urandom & 32'hFF00_0000) | 32'($urandom_range(0, 12)));
      end else if (r <= 6) begin
        wr(BASE + 2 * ch + 1, ($urandom & 32'h7FFF_0000) | 32'($urandom_range(0, 4))
                              | (($urandom_range(0, 7) == 0) ? 32'h8000_0000 : 32'h0));
      end
      addr = 32'(BASE - 2 + $urandom_range(0, 12));
      idle($urandom_range(0, 12));
    end

    // Reset in the middle of a sounding note
    wr(BASE + 0, 32'd3);
    wr(BASE + 1, 32'd0);
    idle(20);
    reset = 1'b1;
    step();
    check("midreset_audio", 32'(audio_out), 32'd0);
    check("midreset_active", 32'(active), 32'd0);
    reset = 1'b0;
    idle(5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
